// File: rtl/booth_mul_arbiter_pkg.sv
// Shared types and default sizing for the Booth multiplier arbiter.
// FSM encoding and an index-width helper live here.
package booth_mul_arbiter_pkg;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_TIMEOUT = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/booth_mul_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request
// after ptr_i, wrapping modulo NREQ.
module booth_mul_arbiter_rr_pick
  import booth_mul_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[IW'(j)]) begin
        any_o           = 1'b1;
        idx_o           = IW'(j);
        gnt_o[IW'(j)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end sharing one sequential signed multiplier
// among NREQ clients, with a completion watchdog.
module booth_mul_arbiter
  import booth_mul_arbiter_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2*W-1:0]    rsp_z,
  output logic              rsp_err,
  output logic              busy,
  output logic              mul_start,
  output logic [W-1:0]      mul_x,
  output logic [W-1:0]      mul_y,
  input  logic              mul_valid,
  input  logic [2*W-1:0]    mul_z
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     gnt_idx_q, gnt_idx_d;
  logic [NREQ-1:0]   gnt_oh_q, gnt_oh_d;
  logic [W-1:0]      x_q, x_d;
  logic [W-1:0]      y_q, y_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*W-1:0]    z_q, z_d;
  logic              err_q, err_d;
  logic              valid_q;

  logic [NREQ-1:0]   pick_gnt;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              done;

  booth_mul_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Only a fresh rising edge counts; a level left over from the
  // previous operation is ignored until it drops.
  assign done = mul_valid & ~valid_q;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_oh_d  = gnt_oh_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    z_d       = z_q;
    err_d     = err_q;
    req_ready = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          gnt_idx_d = pick_idx;
          gnt_oh_d  = pick_gnt;
          x_d       = req_a[int'(pick_idx)*W +: W];
          y_d       = req_b[int'(pick_idx)*W +: W];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        req_ready = gnt_oh_q;
        mul_start = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          z_d     = mul_z;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          z_d     = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid = gnt_oh_q;
        rr_ptr_d  = gnt_idx_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= IW'(NREQ - 1);
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      z_q       <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_oh_q  <= gnt_oh_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      z_q       <= z_d;
      err_q     <= err_d;
      valid_q   <= mul_valid;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign mul_x   = x_q;
  assign mul_y   = y_q;
  assign rsp_z   = z_q;
  assign rsp_err = err_q & (state_q == S_RESP);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a behavioural
// multi-cycle multiplier that can be stalled forever.
module tb_booth_mul_arbiter;
  import booth_mul_arbiter_pkg::*;

  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 32;
  localparam int LAT     = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [2*W-1:0]    rsp_z;
  logic              rsp_err;
  logic              busy;
  logic              mul_start;
  logic [W-1:0]      mul_x;
  logic [W-1:0]      mul_y;
  logic              mul_valid;
  logic [2*W-1:0]    mul_z;

  booth_mul_arbiter #(
    .NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_z(rsp_z), .rsp_err(rsp_err), .busy(busy),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_valid(mul_valid), .mul_z(mul_z)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier; dead=1 models one that never completes
  logic              dead = 1'b0;
  logic              m_busy;
  logic [3:0]        m_cnt;
  logic [2*W-1:0]    m_x, m_y;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy    <= 1'b0;
      m_cnt     <= '0;
      m_x       <= '0;
      m_y       <= '0;
      mul_valid <= 1'b0;
      mul_z     <= '0;
    end else if (mul_start) begin
      m_busy    <= 1'b1;
      m_cnt     <= 4'(LAT);
      m_x       <= {{W{mul_x[W-1]}}, mul_x};
      m_y       <= {{W{mul_y[W-1]}}, mul_y};
      mul_valid <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy <= 1'b0;
        if (!dead) begin
          mul_valid <= 1'b1;
          mul_z     <= m_x * m_y;
        end
      end else begin
        m_cnt <= m_cnt - 1'b1;
      end
    end
  end

  typedef struct {
    int idx;
    int z;
    bit err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_start = 0;

  task automatic check(input string nm, input longint act,
                       input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mul_start) n_start++;
    if (!rst && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b expected none",
                 rsp_valid);
      end else begin
        e = sb.pop_front();
        check("rsp_valid", longint'(rsp_valid), longint'(1 << e.idx));
        check("rsp_z", longint'($signed(rsp_z)), longint'(e.z));
        check("rsp_err", longint'(rsp_err), longint'(e.err));
      end
    end
  end

  task automatic push(input int i, input int z, input bit err);
    exp_t t;
    t.idx = i;
    t.z   = z;
    t.err = err;
    sb.push_back(t);
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Wait for n accept pulses; optionally drop each winner's request
  task automatic run_readies(input int n, input bit auto_drop);
    int got;
    got = 0;
    for (int c = 0; c < 2000 && got < n; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got++;
        if (auto_drop) req_valid &= ~req_ready;
      end
    end
    if (got < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got %0d accepts expected %0d",
               got, n);
    end
    req_valid = '0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  int t2a[3] = '{34, -18, 0};
  int t2b[3] = '{-9, -10, 12};
  int t2z[3] = '{-306, 180, 0};
  int s0;
  int k;

  initial begin
    #1;
    check("reset_outputs",
          longint'({req_ready, rsp_valid, rsp_z, rsp_err, busy,
                    mul_start, mul_x, mul_y}), 0);
    do_reset();

    // single requester
    s0 = n_start;
    push(0, 2294, 1'b0);
    set_op(0, 62, 37);
    req_valid = 4'b0001;
    run_readies(1, 1'b1);
    wait_drain();
    check("t1_starts", longint'(n_start - s0), 1);
    check("t1_idle", longint'(busy), 0);

    // signed operands on requester 1
    for (int i = 0; i < 3; i++) begin
      push(1, t2z[i], 1'b0);
      set_op(1, t2a[i], t2b[i]);
      req_valid = 4'b0010;
      run_readies(1, 1'b1);
      wait_drain();
    end

    // two requesters held high alternate
    do_reset();
    set_op(0, 5, -7);
    set_op(2, -128, -128);
    push(0, -35, 1'b0);
    push(2, 16384, 1'b0);
    push(0, -35, 1'b0);
    push(2, 16384, 1'b0);
    req_valid = 4'b0101;
    run_readies(4, 1'b0);
    wait_drain();

    // all four at once
    do_reset();
    s0 = n_start;
    set_op(0, 3, 4);
    set_op(1, -1, 1);
    set_op(2, 127, 127);
    set_op(3, -128, 127);
    push(0, 12, 1'b0);
    push(1, -1, 1'b0);
    push(2, 16129, 1'b0);
    push(3, -16256, 1'b0);
    req_valid = 4'b1111;
    run_readies(4, 1'b1);
    wait_drain();
    check("t4_starts", longint'(n_start - s0), 4);

    // watchdog timeout then normal service
    dead = 1'b1;
    push(1, 0, 1'b1);
    set_op(1, 9, 9);
    req_valid = 4'b0010;
    run_readies(1, 1'b1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rsp_valid == '0 && k < 200);
    check("timeout_cycles", longint'(k), longint'(TIMEOUT + 1));
    wait_drain();
    dead = 1'b0;
    push(1, -21, 1'b0);
    set_op(1, 7, -3);
    req_valid = 4'b0010;
    run_readies(1, 1'b1);
    wait_drain();

    // reset while waiting drops the operation
    dead = 1'b1;
    set_op(3, 10, 10);
    req_valid = 4'b1000;
    run_readies(1, 1'b1);
    repeat (3) @(negedge clk);
    check("wait_busy", longint'(busy), 1);
    rst = 1'b1;
    #1;
    check("midreset_outputs",
          longint'({req_ready, rsp_valid, rsp_z, rsp_err, busy,
                    mul_start, mul_x, mul_y}), 0);
    @(negedge clk);
    rst = 1'b0;
    dead = 1'b0;
    @(negedge clk);
    set_op(0, -5, 6);
    set_op(1, 127, -1);
    set_op(2, -100, 100);
    push(0, -30, 1'b0);
    push(1, -127, 1'b0);
    push(2, -10000, 1'b0);
    req_valid = 4'b0111;
    run_readies(3, 1'b1);
    wait_drain();

    check("sb_empty", longint'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
